// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter sequencing single-cycle accesses to a 256x8 data memory with
// registered read data; one transaction at a time, round-robin or fixed priority.
module dmem_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              done0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic              lastGrant_q, lastGrant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              winner;

   // A tie goes to the port not granted last time unless fixed priority is on.
   always_comb begin
      if (req0 && req1) begin
         winner = (FIXED_PRIO != 0) ? 1'b0 : ~lastGrant_q;
      end else begin
         winner = ~req0;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lastGrant_d = lastGrant_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d     = ISSUE;
               owner_d     = winner;
               lastGrant_d = winner;
               we_d        = winner ? we1 : we0;
               addr_d      = winner ? addr1 : addr0;
               wdata_d     = winner ? wdata1 : wdata0;
            end
         end
         ISSUE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         lastGrant_q <= 1'b1;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         lastGrant_q <= lastGrant_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   // Strobes are gated by rst so a reset landing mid-ISSUE never touches memory.
   assign mem_write = (state_q == ISSUE) && we_q && !rst;
   assign mem_read  = (state_q == ISSUE) && !we_q && !rst;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state_q != IDLE);
   assign owner     = owner_q;

   assign done0  = (state_q == RESP) && !owner_q && !rst;
   assign done1  = (state_q == RESP) && owner_q && !rst;
   assign rdata0 = (done0 && !we_q) ? mem_rdata : '0;
   assign rdata1 = (done1 && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a round-robin instance backed by a
// behavioural memory, plus a fixed-priority instance for tie-break behaviour.
module tb_dmem_port_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, we0, req1, we1;
   logic [7:0] addr0, wdata0, addr1, wdata1;
   logic       done0, done1, memRead, memWrite, busy, owner;
   logic [7:0] rdata0, rdata1, memAddr, memWdata, memRdata;

   logic       fReq0, fReq1, fDone0, fDone1, fMemRead, fMemWrite, fBusy, fOwner;
   logic [7:0] fRdata0, fRdata1, fMemAddr, fMemWdata, fMemRdata;

   logic       loadEn;
   logic [7:0] loadAddr, loadData;
   logic [7:0] mem [256];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       port;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] expRdata;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   dmem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
      .mem_read(memRead), .mem_write(memWrite), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(memRdata), .busy(busy), .owner(owner)
   );

   dmem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dutFixed (
      .clk(clk), .rst(rst),
      .req0(fReq0), .we0(1'b0), .addr0(8'h30), .wdata0(8'h00), .done0(fDone0), .rdata0(fRdata0),
      .req1(fReq1), .we1(1'b0), .addr1(8'h31), .wdata1(8'h00), .done1(fDone1), .rdata1(fRdata1),
      .mem_read(fMemRead), .mem_write(fMemWrite), .mem_addr(fMemAddr), .mem_wdata(fMemWdata),
      .mem_rdata(fMemRdata), .busy(fBusy), .owner(fOwner)
   );

   // Registered-read memory; the load port lets the bench preload contents.
   always @(posedge clk) begin
      if (loadEn) mem[loadAddr] <= loadData;
      else if (memWrite) mem[memAddr] <= memWdata;
      if (memRead) memRdata <= mem[memAddr];
   end

   // The fixed-priority instance reads a synthetic pattern: data = addr ^ 0x5A.
   always @(posedge clk) begin
      if (fMemRead) fMemRdata <= fMemAddr ^ 8'h5A;
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %02h expected %02h", name, actual, expected);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      loadEn = 1'b1; loadAddr = a; loadData = d;
      @(posedge clk); #1;
      loadEn = 1'b0;
   endtask

   // Runs one full transaction on a single port and checks every cycle of it.
   task automatic applyStimulus(input logic port, input logic we, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic [7:0] expRdata);
      if (!port) begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      end
      @(posedge clk); #1;
      checkOutput("issue_busy", busy, 1);
      checkOutput("issue_owner", owner, port);
      checkOutput("issue_mem_write", memWrite, we);
      checkOutput("issue_mem_read", memRead, !we);
      checkOutput("issue_mem_addr", memAddr, addr);
      if (we) checkOutput("issue_mem_wdata", memWdata, wdata);
      checkOutput("issue_done0", done0, 0);
      checkOutput("issue_done1", done1, 0);
      @(posedge clk); #1;
      checkOutput("resp_done_owner", port ? done1 : done0, 1);
      checkOutput("resp_done_other", port ? done0 : done1, 0);
      checkOutput("resp_rdata_owner", port ? rdata1 : rdata0, we ? 8'h00 : expRdata);
      checkOutput("resp_rdata_other", port ? rdata0 : rdata1, 8'h00);
      checkOutput("resp_mem_strobes", {memRead, memWrite}, 0);
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", {done0, done1}, 0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
      vecs[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
      vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'h01, 8'h00};
      vecs[3] = '{1'b1, 1'b1, 8'h00, 8'hFE, 8'h00};
      vecs[4] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h01};
      vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hFE};
      vecs[6] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h01};
      vecs[7] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};

      rst = 1'b1;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      fReq0 = 0; fReq1 = 0;
      loadEn = 0; loadAddr = 0; loadData = 0;
      @(posedge clk); #1;
      preload(8'h20, 8'h3C);
      preload(8'h21, 8'h7E);
      preload(8'h40, 8'h11);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_owner", owner, 0);
      checkOutput("reset_mem_addr", memAddr, 8'h00);
      checkOutput("reset_mem_wdata", memWdata, 8'h00);
      checkOutput("reset_strobes", {memRead, memWrite, done0, done1}, 0);
      checkOutput("reset_rdata0", rdata0, 8'h00);
      checkOutput("reset_rdata1", rdata1, 8'h00);
      rst = 1'b0;

      // First tie after reset goes to port 0, the next one to port 1.
      req0 = 1; addr0 = 8'h20; req1 = 1; addr1 = 8'h21;
      @(posedge clk); #1;
      checkOutput("tie1_owner", owner, 0);
      checkOutput("tie1_addr", memAddr, 8'h20);
      @(posedge clk); #1;
      checkOutput("tie1_done0", done0, 1);
      checkOutput("tie1_done1", done1, 0);
      checkOutput("tie1_rdata0", rdata0, 8'h3C);
      @(posedge clk); #1;
      checkOutput("tie1_idle", busy, 0);
      @(posedge clk); #1;
      checkOutput("tie2_owner", owner, 1);
      checkOutput("tie2_addr", memAddr, 8'h21);
      @(posedge clk); #1;
      checkOutput("tie2_done1", done1, 1);
      checkOutput("tie2_done0", done0, 0);
      checkOutput("tie2_rdata1", rdata1, 8'h7E);
      checkOutput("tie2_rdata0", rdata0, 8'h00);
      req1 = 0;
      @(posedge clk); #1;
      checkOutput("tie2_idle", busy, 0);
      @(posedge clk); #1;
      checkOutput("tie3_owner", owner, 0);
      @(posedge clk); #1;
      checkOutput("tie3_rdata0", rdata0, 8'h3C);
      req0 = 0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expRdata);
      end

      // Reset lands during the ISSUE cycle of a write; memory must be untouched.
      req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 8'h99;
      @(posedge clk); #1;
      checkOutput("rst_pre_mem_write", memWrite, 1);
      rst = 1'b1;
      #1;
      checkOutput("rst_mem_write", memWrite, 0);
      checkOutput("rst_done0", done0, 0);
      req0 = 0; we0 = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_owner", owner, 0);
      checkOutput("rst_mem_addr", memAddr, 8'h00);
      @(posedge clk); #1;
      checkOutput("rst_no_done", {done0, busy}, 0);
      applyStimulus(1'b0, 1'b0, 8'h40, 8'h00, 8'h11);

      // Fixed priority: port 0 keeps winning while both request.
      fReq0 = 1; fReq1 = 1;
      @(posedge clk); #1;
      checkOutput("fix1_owner", fOwner, 0);
      @(posedge clk); #1;
      checkOutput("fix1_rdata0", fRdata0, 8'h6A);
      checkOutput("fix1_done1", fDone1, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("fix2_owner", fOwner, 0);
      @(posedge clk); #1;
      checkOutput("fix2_done0", fDone0, 1);
      fReq0 = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("fix3_owner", fOwner, 1);
      @(posedge clk); #1;
      checkOutput("fix3_done1", fDone1, 1);
      checkOutput("fix3_rdata1", fRdata1, 8'h6B);
      fReq1 = 0;
      @(posedge clk); #1;
      checkOutput("fix3_idle", fBusy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
